nonce_collect: RTL and testbench
================================

NONCE_COLLECT -- requirements
Module: nonce_collect

Interface
- REQ-001: Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
- REQ-002: clk  input  1  single clock; all state SHALL be on its rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: found  input  1  hash-below-target flag from the upstream compare stage.
- REQ-005: busy  input  1  qualifies found/nonce as a valid hashing result.
- REQ-006: nonce  input  32  nonce associated with found, same cycle.
- REQ-007: clear  input  1  synchronous job flush.
- REQ-008: out_valid  output  1  a nonce is available at the FIFO head.
- REQ-009: out_ready  input  1  host accepts the head entry.
- REQ-010: out_nonce  output  32  head entry, first-word fall-through.
- REQ-011: count  output  $clog2(DEPTH)+1  current occupancy.
- REQ-012: overflow  output  1  sticky: a hit was dropped because the FIFO was full.
- REQ-013: hit_count  output  32  number of qualified hits since reset/clear.

Function
- REQ-014: A hit SHALL be the cycle in which busy=1 and found=1; found with busy=0 SHALL be ignored.
- REQ-015: Push: a hit with count<DEPTH SHALL write nonce into the FIFO tail.
- REQ-016: Latency: a hit at edge N SHALL make out_valid=1 with out_nonce=that nonce after edge N+1 when the FIFO was empty.
- REQ-017: out_valid SHALL equal (count!=0); out_nonce SHALL be the oldest entry and stay stable while out_valid=1 and out_ready=0.
- REQ-018: Pop: out_valid=1 and out_ready=1 at an edge SHALL remove the head; out_ready with out_valid=0 SHALL have no effect.
- REQ-019: Full: a hit with count=DEPTH and no simultaneous pop SHALL be dropped and set overflow=1.
- REQ-020: Full with a simultaneous pop and hit SHALL push and pop together; count stays DEPTH; overflow unchanged.
- REQ-021: Simultaneous push and pop at any non-empty occupancy SHALL leave count unchanged.
- REQ-022: Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
- REQ-023: hit_count SHALL increment on every qualified hit, including dropped ones, and saturate at 0xFFFFFFFF.
- REQ-024: clear=1 SHALL empty the FIFO, zero count and hit_count, and clear overflow at the next edge; it overrides a same-cycle hit or pop, and the hit is discarded.

Reset
- REQ-025: rst_n=0 SHALL asynchronously force out_valid=0, count=0, overflow=0, hit_count=0, pointers=0; out_nonce SHALL read 0.
- REQ-026: Reset asserted mid-operation SHALL discard all stored entries; the FIFO RAM contents need not be cleared.

Configuration
- REQ-027: Macro NONCE_COLLECT_DEDUP_EN, when defined, SHALL hold the last pushed nonce plus a valid bit (cleared by reset/clear).
- REQ-028: With the macro defined, a hit whose nonce equals the last pushed nonce SHALL be neither pushed nor counted in hit_count.
- REQ-029: Without the macro, every qualified hit SHALL be handled per REQ-015..023 and no compare logic SHALL exist.

Structure
- REQ-030: Shared package siaminer_pkg SHALL hold NONCE_W=32 and NONCE_FIFO_DEPTH=8, used as the default for DEPTH.
- REQ-031: Storage and pointers SHALL live in a sub-module nonce_fifo, a synchronous FWFT FIFO with push/pop/full/empty/count.

Verification
- REQ-032: Single hit: busy=1, found=1, nonce=0x12345678 at edge 0 -> out_valid=1, out_nonce=0x12345678 after edge 1, count=1, hit_count=1.
- REQ-033: Qualification: found=1, busy=0 for 10 cycles -> out_valid=0, hit_count=0.
- REQ-034: Overflow: out_ready=0, DEPTH+2 hits with nonces 1..10 -> count=8, overflow=1, hit_count=10; drain pops 1..8 in order.
- REQ-035: Full push+pop: FIFO full with 1..8, hit nonce=0xAA with out_ready=1 -> count stays 8, overflow=0, drain order 2..8, 0xAA.
- REQ-036: Clear/reset: FIFO holds 3 entries, clear=1 with a same-cycle hit -> count=0, out_valid=0, hit_count=0; repeat with rst_n pulsed low mid-cycle -> all outputs 0 immediately.
- REQ-037: Dedup (macro defined): hits 0x55, 0x55, 0x66 -> pushed 0x55, 0x66, hit_count=2; macro undefined -> three entries, hit_count=3.

Source files
------------

// File: rtl/siaminer_pkg.sv
// Shared constants for the miner datapath: nonce width and the default
// depth of the winning-nonce FIFO.
package siaminer_pkg;
  localparam int NONCE_W          = 32;
  localparam int NONCE_FIFO_DEPTH = 8;
  localparam logic [31:0] HIT_COUNT_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/nonce_fifo.sv
// Synchronous first-word-fall-through FIFO with push/pop/full/empty/count.
// clr flushes all state and takes priority over push and pop.
module nonce_fifo
  import siaminer_pkg::*;
#(
  parameter int DEPTH = NONCE_FIFO_DEPTH,
  parameter int W     = NONCE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  // NOTE: every variable gets a default first so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/nonce_collect.sv
// Collects qualified winning nonces into a FIFO for the host, with overflow and hit counters.
// Optional NONCE_COLLECT_DEDUP_EN suppresses a hit that repeats the last pushed nonce.
module nonce_collect
  import siaminer_pkg::*;
#(
  parameter int DEPTH = NONCE_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     found,
  input  logic                     busy,
  input  logic [NONCE_W-1:0]       nonce,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NONCE_W-1:0]       out_nonce,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              hit_count
);

  logic        hit, hit_eff, pop, full, empty;
  logic        overflow_q, overflow_d;
  logic [31:0] hit_count_q, hit_count_d;

  assign hit = busy & found;
  assign pop = out_ready & ~empty;

`ifdef NONCE_COLLECT_DEDUP_EN
  logic [NONCE_W-1:0] last_q, last_d;
  logic               last_vld_q, last_vld_d;

  assign hit_eff = hit & ~(last_vld_q && (nonce == last_q));

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (clear) begin
      last_vld_d = 1'b0;
    end else if (hit_eff && (!full || pop)) begin
      last_d     = nonce;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign hit_eff = hit;
`endif

  always_comb begin
    overflow_d  = overflow_q;
    hit_count_d = hit_count_q;
    if (clear) begin
      overflow_d  = 1'b0;
      hit_count_d = '0;
    end else if (hit_eff) begin
      if (full && !pop) overflow_d = 1'b1;
      if (hit_count_q != HIT_COUNT_MAX) hit_count_d = hit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      hit_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      hit_count_q <= hit_count_d;
    end
  end

  nonce_fifo #(.DEPTH(DEPTH), .W(NONCE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (hit_eff),
    .din   (nonce),
    .pop   (pop),
    .dout  (out_nonce),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = ~empty;
  assign overflow  = overflow_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_nonce_collect.sv
// Self-checking bench for nonce_collect: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_nonce_collect;
  import siaminer_pkg::*;

  localparam int DEPTH = NONCE_FIFO_DEPTH;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   found, busy, clear, out_ready;
  logic [31:0]            nonce;
  logic                   out_valid, overflow;
  logic [31:0]            out_nonce, hit_count;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned mq[$];
  bit          m_ovf;
  int unsigned m_hits;
  bit          m_last_vld;
  int unsigned m_last;

  always #5 clk = ~clk;

  nonce_collect #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .found     (found),
    .busy      (busy),
    .nonce     (nonce),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nonce (out_nonce),
    .count     (count),
    .overflow  (overflow),
    .hit_count (hit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_hits     = 0;
    m_last_vld = 1'b0;
    m_last     = 0;
  endtask

  // Applies one rising edge of the specification's rules to the model.
  task automatic model_edge();
    bit do_pop, is_hit;
    if (clear) begin
      model_reset();
      return;
    end
    do_pop = out_ready && (mq.size() > 0);
    is_hit = busy && found;
`ifdef NONCE_COLLECT_DEDUP_EN
    if (is_hit && m_last_vld && (nonce == m_last)) is_hit = 1'b0;
`endif
    if (is_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
    if (do_pop) void'(mq.pop_front());
    if (is_hit) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(nonce);
        m_last_vld = 1'b1;
        m_last     = nonce;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".out_nonce"}, out_nonce,      (mq.size() != 0) ? mq[0] : 32'd0);
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".hit_count"}, hit_count,      m_hits);
  endtask

  // Drive one cycle of inputs, step the model, then sample 1 time unit after the edge.
  task automatic cycle(input bit b, input bit f, input logic [31:0] n,
                       input bit c, input bit r, input string tag);
    busy = b; found = f; nonce = n; clear = c; out_ready = r;
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_ready(input bit r);
    busy = 1'b0; found = 1'b0; clear = 1'b0; out_ready = r; nonce = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ready(1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    // Single hit becomes visible right after the sampling edge
    cycle(1, 1, 32'h1234_5678, 0, 0, "single");
    check("single.head", out_nonce, 32'h1234_5678);
    check("single.hits", hit_count, 32'd1);
    cycle(0, 0, 0, 0, 1, "single_pop");
    cycle(0, 0, 0, 1, 0, "clr0");

    // found without busy is ignored
    for (int i = 0; i < 10; i++) cycle(0, 1, 32'(i + 100), 0, 0, "qual");
    check("qual.valid", 32'(out_valid), 32'd0);
    check("qual.hits", hit_count, 32'd0);

    // Overflow: DEPTH+2 hits without popping
    for (int i = 1; i <= DEPTH + 2; i++) cycle(1, 1, 32'(i), 0, 0, "ovf_fill");
    check("ovf.count", 32'(count), 32'(DEPTH));
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.hits", hit_count, 32'(DEPTH + 2));
    for (int i = 1; i <= DEPTH; i++) begin
      check("ovf.drain", out_nonce, 32'(i));
      cycle(0, 0, 0, 0, 1, "ovf_drain");
    end
    check("ovf.empty", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 0, 1, "pop_empty");

    // Full with simultaneous hit and pop
    cycle(0, 0, 0, 1, 0, "clr1");
    for (int i = 1; i <= DEPTH; i++) cycle(1, 1, 32'(i), 0, 0, "fpp_fill");
    cycle(1, 1, 32'hAA, 0, 1, "fpp");
    check("fpp.count", 32'(count), 32'(DEPTH));
    check("fpp.flag", 32'(overflow), 32'd0);
    for (int i = 2; i <= DEPTH + 1; i++) begin
      check("fpp.drain", out_nonce, (i <= DEPTH) ? 32'(i) : 32'hAA);
      cycle(0, 0, 0, 0, 1, "fpp_drain");
    end

    // Clear overrides a same-cycle hit
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'(200 + i), 0, 0, "clr_fill");
    cycle(1, 1, 32'hDEAD, 1, 1, "clr_hit");
    check("clr.count", 32'(count), 32'd0);
    check("clr.valid", 32'(out_valid), 32'd0);
    check("clr.hits", hit_count, 32'd0);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'(300 + i), 0, 0, "rst_fill");
    idle_ready(1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all("post_rst");

    // Repeated nonce
    cycle(1, 1, 32'h55, 0, 0, "dedup");
    cycle(1, 1, 32'h55, 0, 0, "dedup");
    cycle(1, 1, 32'h66, 0, 0, "dedup");
`ifdef NONCE_COLLECT_DEDUP_EN
    check("dedup.hits", hit_count, 32'd2);
    check("dedup.count", 32'(count), 32'd2);
`else
    check("dedup.hits", hit_count, 32'd3);
    check("dedup.count", 32'(count), 32'd3);
`endif
    check("dedup.head", out_nonce, 32'h55);
    cycle(0, 0, 0, 1, 0, "clr2");

    // Randomized traffic with varying host readiness
    for (int i = 0; i < 800; i++) begin
      int unsigned ready_pct;
      logic [31:0] n;
      ready_pct = ((i / 100) % 4) * 30;
      n = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cycle(($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 60), n,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < ready_pct), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
